uart_framed: RTL and testbench



---
 rtl/uart_framed.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_framed.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_framed.sv
// Parametrised full-duplex UART: shared oversampling tick, majority-voted RX with
// parity/framing/overrun reporting held until acknowledged, and a framed TX.
module uart_framed #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLING  = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 tx,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy
);

    localparam int SAMPLE_RATE = BAUD_RATE * OVERSAMPLING;
    localparam int DIV_RAW     = (CLK_FREQUENCY + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int DIV         = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW          = $clog2(OVERSAMPLING);
    localparam int BW          = $clog2(DATA_BITS + 1);
    localparam int TW          = $clog2(OVERSAMPLING * DIV);
    localparam int M           = OVERSAMPLING / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
    localparam logic [SW-1:0] SAMPLE_A    = SW'(M - 1);
    localparam logic [SW-1:0] SAMPLE_B    = SW'(M);
    localparam logic [SW-1:0] SAMPLE_C    = SW'(M + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] DATA_LAST   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST   = BW'(STOP_BITS - 1);
    localparam logic [TW-1:0] TX_LAST     = TW'(OVERSAMPLING * DIV - 1);
    localparam logic          PARITY_ODD  = (PARITY_MODE == 1);
    localparam logic [2:0]    AFTER_DATA  = (PARITY_MODE != 0) ? S_PARITY : S_STOP;

    logic [DW-1:0] divCnt_q;
    logic          tick;

    assign tick = (divCnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) divCnt_q <= '0;
        else       divCnt_q <= tick ? '0 : divCnt_q + 1'b1;
    end

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    logic [1:0] rxSync_q;
    logic       rxIn;

    assign rxIn = rxSync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rxSync_q <= 2'b11;
        else       rxSync_q <= {rxSync_q[0], rx};
    end

    logic [2:0]           rxState_q, rxState_d;
    logic [SW-1:0]        rxCnt_q, rxCnt_d;
    logic [BW-1:0]        rxBit_q, rxBit_d;
    logic [1:0]           rxHist_q, rxHist_d;
    logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
    logic                 rxParErr_q, rxParErr_d;
    logic                 vote, voteNow, bitEnd, frameDone, frameErrNew, rxExpPar;

    assign vote     = (rxHist_q[1] & rxHist_q[0]) | (rxHist_q[1] & rxIn) | (rxHist_q[0] & rxIn);
    assign voteNow  = tick && (rxCnt_q == SAMPLE_C);
    assign bitEnd   = tick && (rxCnt_q == SAMPLE_LAST);
    assign rxExpPar = (^rxShift_q) ^ PARITY_ODD;

    always_comb begin
        rxState_d   = rxState_q;
        rxCnt_d     = rxCnt_q;
        rxBit_d     = rxBit_q;
        rxHist_d    = rxHist_q;
        rxShift_d   = rxShift_q;
        rxParErr_d  = rxParErr_q;
        frameDone   = 1'b0;
        frameErrNew = 1'b0;
        if (tick && rxState_q != S_IDLE) begin
            rxCnt_d = rxCnt_q + 1'b1;
            if (rxCnt_q == SAMPLE_A) rxHist_d[0] = rxIn;
            if (rxCnt_q == SAMPLE_B) rxHist_d[1] = rxIn;
        end
        case (rxState_q)
            S_IDLE: begin
                if (tick && !rxIn) begin
                    rxState_d  = S_START;
                    rxCnt_d    = '0;
                    rxBit_d    = '0;
                    rxParErr_d = 1'b0;
                end
            end
            S_START: begin
                if (voteNow && vote) begin
                    rxState_d = S_IDLE;
                end else if (bitEnd) begin
                    rxState_d = S_DATA;
                    rxCnt_d   = '0;
                end
            end
            S_DATA: begin
                if (voteNow) rxShift_d = {vote, rxShift_q[DATA_BITS-1:1]};
                if (bitEnd) begin
                    rxCnt_d = '0;
                    if (rxBit_q == DATA_LAST) begin
                        rxBit_d   = '0;
                        rxState_d = AFTER_DATA;
                    end else begin
                        rxBit_d = rxBit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (voteNow && (vote != rxExpPar)) rxParErr_d = 1'b1;
                if (bitEnd) begin
                    rxState_d = S_STOP;
                    rxCnt_d   = '0;
                end
            end
            S_STOP: begin
                // Finish at mid-stop so a start edge inside the stop bit can resync.
                if (voteNow) begin
                    frameDone   = 1'b1;
                    frameErrNew = ~vote;
                    rxState_d   = S_IDLE;
                end
            end
            default: rxState_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxState_q  <= S_IDLE;
            rxCnt_q    <= '0;
            rxBit_q    <= '0;
            rxHist_q   <= '0;
            rxShift_q  <= '0;
            rxParErr_q <= 1'b0;
        end else begin
            rxState_q  <= rxState_d;
            rxCnt_q    <= rxCnt_d;
            rxBit_q    <= rxBit_d;
            rxHist_q   <= rxHist_d;
            rxShift_q  <= rxShift_d;
            rxParErr_q <= rxParErr_d;
        end
    end

    // A completing frame takes priority over a simultaneous acknowledge.
    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxValid_q, rxParityErr_q, rxFrameErr_q, rxOverrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxData_q      <= '0;
            rxValid_q     <= 1'b0;
            rxParityErr_q <= 1'b0;
            rxFrameErr_q  <= 1'b0;
            rxOverrun_q   <= 1'b0;
        end else if (frameDone) begin
            rxData_q      <= rxShift_q;
            rxValid_q     <= 1'b1;
            rxParityErr_q <= rxParErr_q;
            rxFrameErr_q  <= frameErrNew;
            rxOverrun_q   <= rxValid_q & ~rx_ack;
        end else if (rx_ack && rxValid_q) begin
            rxValid_q     <= 1'b0;
            rxParityErr_q <= 1'b0;
            rxFrameErr_q  <= 1'b0;
            rxOverrun_q   <= 1'b0;
        end
    end

    assign rx_data       = rxData_q;
    assign rx_valid      = rxValid_q;
    assign rx_parity_err = rxParityErr_q;
    assign rx_frame_err  = rxFrameErr_q;
    assign rx_overrun    = rxOverrun_q;

    // TX bit timer restarts at acceptance so every bit is exactly OVERSAMPLING*DIV clocks.
    logic [2:0]           txState_q, txState_d;
    logic [TW-1:0]        txTimer_q, txTimer_d;
    logic [BW-1:0]        txBit_q, txBit_d;
    logic [DATA_BITS-1:0] txShift_q, txShift_d;
    logic                 txPar_q, txPar_d, tx_q, tx_d, txBusy_q, txBusy_d, txBitDone;

    assign txBitDone = (txTimer_q == TX_LAST);

    always_comb begin
        txState_d = txState_q;
        txTimer_d = txTimer_q;
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        txPar_d   = txPar_q;
        tx_d      = tx_q;
        txBusy_d  = txBusy_q;
        if (txState_q != S_IDLE) txTimer_d = txBitDone ? '0 : txTimer_q + 1'b1;
        case (txState_q)
            S_IDLE: begin
                if (tx_start) begin
                    txShift_d = tx_data;
                    txPar_d   = (^tx_data) ^ PARITY_ODD;
                    txState_d = S_START;
                    txTimer_d = '0;
                    txBit_d   = '0;
                    tx_d      = 1'b0;
                    txBusy_d  = 1'b1;
                end
            end
            S_START: begin
                if (txBitDone) begin
                    txState_d = S_DATA;
                    tx_d      = txShift_q[0];
                end
            end
            S_DATA: begin
                if (txBitDone) begin
                    if (txBit_q == DATA_LAST) begin
                        txBit_d   = '0;
                        txState_d = AFTER_DATA;
                        tx_d      = (PARITY_MODE != 0) ? txPar_q : 1'b1;
                    end else begin
                        txBit_d   = txBit_q + 1'b1;
                        txShift_d = txShift_q >> 1;
                        tx_d      = txShift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (txBitDone) begin
                    txState_d = S_STOP;
                    txBit_d   = '0;
                    tx_d      = 1'b1;
                end
            end
            S_STOP: begin
                if (txBitDone) begin
                    if (txBit_q == STOP_LAST) begin
                        txState_d = S_IDLE;
                        txBit_d   = '0;
                        txBusy_d  = 1'b0;
                        tx_d      = 1'b1;
                    end else begin
                        txBit_d = txBit_q + 1'b1;
                    end
                end
            end
            default: begin
                txState_d = S_IDLE;
                tx_d      = 1'b1;
                txBusy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState_q <= S_IDLE;
            txTimer_q <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            txPar_q   <= 1'b0;
            tx_q      <= 1'b1;
            txBusy_q  <= 1'b0;
        end else begin
            txState_q <= txState_d;
            txTimer_q <= txTimer_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            txPar_q   <= txPar_d;
            tx_q      <= tx_d;
            txBusy_q  <= txBusy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = txBusy_q;

endmodule

// File: tb/tb_uart_framed.sv
// Directed bench: three uart_framed instances (8N1, 8E1, 8N2) at 16 clocks per bit,
// with TX loopback or a bench-driven RX line.
module tb_uart_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic lineDrv, lineSel, loopA, loopB;
    int   testsRun = 0;
    int   testsFailed = 0;

    logic       rxA, rxAckA, txStartA, rxValidA, rxParErrA, rxFrameErrA, rxOverrunA, txA, txBusyA;
    logic [7:0] txDataA, rxDataA;
    logic       rxB, rxAckB, txStartB, rxValidB, rxParErrB, rxFrameErrB, rxOverrunB, txB, txBusyB;
    logic [7:0] txDataB, rxDataB;
    logic       rxC, rxAckC, txStartC, rxValidC, rxParErrC, rxFrameErrC, rxOverrunC, txC, txBusyC;
    logic [7:0] txDataC, rxDataC;

    int   txSel;
    logic txObs, busyObs;

    assign rxA     = loopA ? txA : ((lineSel == 1'b0) ? lineDrv : 1'b1);
    assign rxB     = loopB ? txB : ((lineSel == 1'b1) ? lineDrv : 1'b1);
    assign rxC     = 1'b1;
    assign txObs   = (txSel == 0) ? txA : (txSel == 1) ? txB : txC;
    assign busyObs = (txSel == 0) ? txBusyA : (txSel == 1) ? txBusyB : txBusyC;

    uart_framed #(.CLK_FREQUENCY(16000000), .BAUD_RATE(1000000), .OVERSAMPLING(16),
                  .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset(reset), .rx(rxA), .rx_data(rxDataA), .rx_valid(rxValidA),
        .rx_ack(rxAckA), .rx_parity_err(rxParErrA), .rx_frame_err(rxFrameErrA),
        .rx_overrun(rxOverrunA), .tx(txA), .tx_start(txStartA), .tx_data(txDataA),
        .tx_busy(txBusyA));

    uart_framed #(.CLK_FREQUENCY(16000000), .BAUD_RATE(1000000), .OVERSAMPLING(16),
                  .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dutB (
        .clk(clk), .reset(reset), .rx(rxB), .rx_data(rxDataB), .rx_valid(rxValidB),
        .rx_ack(rxAckB), .rx_parity_err(rxParErrB), .rx_frame_err(rxFrameErrB),
        .rx_overrun(rxOverrunB), .tx(txB), .tx_start(txStartB), .tx_data(txDataB),
        .tx_busy(txBusyB));

    uart_framed #(.CLK_FREQUENCY(16000000), .BAUD_RATE(1000000), .OVERSAMPLING(16),
                  .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dutC (
        .clk(clk), .reset(reset), .rx(rxC), .rx_data(rxDataC), .rx_valid(rxValidC),
        .rx_ack(rxAckC), .rx_parity_err(rxParErrC), .rx_frame_err(rxFrameErrC),
        .rx_overrun(rxOverrunC), .tx(txC), .tx_start(txStartC), .tx_data(txDataC),
        .tx_busy(txBusyC));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse tx_start on the chosen instance, then sample the line mid-bit and count busy clocks.
    task automatic transmit(input int sel, input logic [7:0] data, output logic [11:0] bits, output int busyCnt);
        txSel   = sel;
        bits    = '1;
        busyCnt = 0;
        @(negedge clk);
        txDataA = data;
        txDataB = data;
        txDataC = data;
        if (sel == 0)      txStartA = 1'b1;
        else if (sel == 1) txStartB = 1'b1;
        else               txStartC = 1'b1;
        @(negedge clk);
        txStartA = 1'b0;
        txStartB = 1'b0;
        txStartC = 1'b0;
        for (int c = 0; c < 220; c++) begin
            if (busyObs) busyCnt++;
            if ((c % 16 == 8) && (c / 16 < 12)) bits[c / 16] = txObs;
            @(negedge clk);
        end
    endtask

    task automatic driveBit(input logic b);
        lineDrv = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic driveFrame(input logic [7:0] data, input logic hasPar, input logic parBit, input logic stopBit);
        @(negedge clk);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        if (hasPar) driveBit(parBit);
        driveBit(stopBit);
        driveBit(1'b1);
    endtask

    task automatic applyStimulus(input int sel);
        @(negedge clk);
        if (sel == 0) rxAckA = 1'b1;
        else          rxAckB = 1'b1;
        @(negedge clk);
        rxAckA = 1'b0;
        rxAckB = 1'b0;
    endtask

    logic [11:0] bits;
    int          busyCnt;

    initial begin
        reset = 1'b1;
        lineDrv = 1'b1; lineSel = 1'b0; loopA = 1'b1; loopB = 1'b1;
        rxAckA = 1'b0; txStartA = 1'b0; txDataA = '0;
        rxAckB = 1'b0; txStartB = 1'b0; txDataB = '0;
        rxAckC = 1'b0; txStartC = 1'b0; txDataC = '0;
        txSel = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", 32'(txA), 32'd1);
        checkOutput("reset tx_busy", 32'(txBusyA), 32'd0);
        checkOutput("reset rx_valid", 32'(rxValidA), 32'd0);
        checkOutput("reset rx_data", 32'(rxDataA), 32'd0);
        checkOutput("reset errors", 32'({rxParErrA, rxFrameErrA, rxOverrunA}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 loopback of 0xA5
        transmit(0, 8'hA5, bits, busyCnt);
        checkOutput("t1 tx bits", 32'(bits[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
        checkOutput("t1 busy clocks", 32'(busyCnt), 32'd160);
        checkOutput("t1 rx_valid", 32'(rxValidA), 32'd1);
        checkOutput("t1 rx_data", 32'(rxDataA), 32'hA5);
        checkOutput("t1 errors", 32'({rxParErrA, rxFrameErrA, rxOverrunA}), 32'd0);
        applyStimulus(0);
        checkOutput("t1 ack clears valid", 32'(rxValidA), 32'd0);

        // Even parity: 0x07 carries parity 1, then a forced-bad parity frame
        transmit(1, 8'h07, bits, busyCnt);
        checkOutput("t2 tx bits", 32'(bits[10:0]), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
        checkOutput("t2 busy clocks", 32'(busyCnt), 32'd176);
        checkOutput("t2 loop rx_data", 32'(rxDataB), 32'h07);
        checkOutput("t2 loop parity ok", 32'(rxParErrB), 32'd0);
        applyStimulus(1);
        loopB = 1'b0;
        lineSel = 1'b1;
        driveFrame(8'h07, 1'b1, 1'b0, 1'b1);
        checkOutput("t2 rx_valid", 32'(rxValidB), 32'd1);
        checkOutput("t2 rx_data", 32'(rxDataB), 32'h07);
        checkOutput("t2 parity err", 32'(rxParErrB), 32'd1);
        checkOutput("t2 frame/overrun", 32'({rxFrameErrB, rxOverrunB}), 32'd0);
        applyStimulus(1);
        checkOutput("t2 ack clears parity", 32'(rxParErrB), 32'd0);

        // Low stop bit on 0x3C, then a clean 0x11
        loopA = 1'b0;
        lineSel = 1'b0;
        driveFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("t3 frame err", 32'(rxFrameErrA), 32'd1);
        checkOutput("t3 rx_data", 32'(rxDataA), 32'h3C);
        checkOutput("t3 rx_valid", 32'(rxValidA), 32'd1);
        applyStimulus(0);
        driveFrame(8'h11, 1'b0, 1'b0, 1'b1);
        checkOutput("t3 clean frame err", 32'(rxFrameErrA), 32'd0);
        checkOutput("t3 clean rx_data", 32'(rxDataA), 32'h11);
        applyStimulus(0);

        // Glitch shorter than half a bit must be rejected
        @(negedge clk);
        lineDrv = 1'b0;
        repeat (4) @(negedge clk);
        lineDrv = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("t4 no valid on glitch", 32'(rxValidA), 32'd0);
        driveFrame(8'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("t4 rx_data", 32'(rxDataA), 32'h55);
        checkOutput("t4 rx_valid", 32'(rxValidA), 32'd1);
        applyStimulus(0);

        // Two frames without acknowledge
        driveFrame(8'h12, 1'b0, 1'b0, 1'b1);
        checkOutput("t5 first no overrun", 32'(rxOverrunA), 32'd0);
        driveFrame(8'h34, 1'b0, 1'b0, 1'b1);
        checkOutput("t5 rx_data", 32'(rxDataA), 32'h34);
        checkOutput("t5 overrun", 32'(rxOverrunA), 32'd1);
        applyStimulus(0);
        checkOutput("t5 ack clears overrun", 32'(rxOverrunA), 32'd0);
        checkOutput("t5 ack clears valid", 32'(rxValidA), 32'd0);

        // Reset 50 clocks into a 0xFF frame, then clean frames on 8N1 and 8N2
        txSel = 0;
        @(negedge clk);
        txDataA = 8'hFF;
        txStartA = 1'b1;
        @(negedge clk);
        txStartA = 1'b0;
        repeat (49) @(negedge clk);
        checkOutput("t6 busy before reset", 32'(txBusyA), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t6 reset tx", 32'(txA), 32'd1);
        checkOutput("t6 reset busy", 32'(txBusyA), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        transmit(0, 8'h81, bits, busyCnt);
        checkOutput("t6 tx bits", 32'(bits[9:0]), 32'({1'b1, 8'h81, 1'b0}));
        checkOutput("t6 busy clocks", 32'(busyCnt), 32'd160);
        transmit(2, 8'h81, bits, busyCnt);
        checkOutput("t6 2stop tx bits", 32'(bits[10:0]), 32'({2'b11, 8'h81, 1'b0}));
        checkOutput("t6 2stop busy clocks", 32'(busyCnt), 32'd176);
        checkOutput("idle rx on 8N2", 32'({rxValidC, rxParErrC, rxFrameErrC, rxOverrunC, rxDataC}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
